opr1_sequencer: RTL and testbench

OPR1_SEQUENCER -- requirements
Module: opr1_sequencer

---
 rtl/opr1_pkg.sv | 31 +++
 rtl/opr1_rotator.sv | 22 ++
 rtl/opr1_sequencer.sv | 119 +++++++++++
 tb/tb_opr1_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/opr1_pkg.sv
// Shared definitions for the PDP-8 group-1 operate sequencer.
// Optional byte-swap (BSW) support is enabled with OPR1_BSW_EN.
package opr1_pkg;

    localparam int W = 12;

    localparam int IR_CLA = 7;
    localparam int IR_CLL = 6;
    localparam int IR_CMA = 5;
    localparam int IR_CML = 4;
    localparam int IR_RAR = 3;
    localparam int IR_RAL = 2;
    localparam int IR_BSW = 1;
    localparam int IR_IAC = 0;

    localparam logic [3:0] GRP1_OP = 4'b1110;

    typedef enum logic [2:0] {
        IDLE,
        CLRCOM,
        INC,
        ROT1,
        ROT2,
        FIN
    } state_t;

    function automatic logic is_grp1(input logic [W-1:0] ir);
        return ir[W-1:W-4] == GRP1_OP;
    endfunction

endpackage

// File: rtl/opr1_rotator.sv
// Single-step rotate of the 13-bit {L,AC} word, or 6-bit half swap of AC.
// dir=1 rotates left, dir=0 rotates right; swap overrides dir.
module opr1_rotator
    import opr1_pkg::*;
(
    input  logic [W:0] din,
    input  logic       dir,
    input  logic       swap,
    output logic [W:0] dout
);

    always_comb begin
        dout = din;
        if (swap)
            dout = {din[W], din[W/2-1:0], din[W-1:W/2]};
        else if (dir)
            dout = {din[W-1:0], din[W]};
        else
            dout = {din[0], din[W:1]};
    end

endmodule

// File: rtl/opr1_sequencer.sv
// Multi-cycle executor for PDP-8 group-1 operate instructions.
// Define OPR1_BSW_EN to enable the BSW (byte swap) encoding.
module opr1_sequencer
    import opr1_pkg::*;
(
    input  logic         CLK,
    input  logic         RESETN,
    input  logic         START,
    input  logic [W-1:0] IR,
    input  logic [W-1:0] AC_IN,
    input  logic         LINK_IN,
    output logic [W-1:0] AC_OUT,
    output logic         LINK_OUT,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR
);

    state_t         state, nxt;
    logic [W-1:0]   ac_q, ac_d;
    logic           l_q, l_d;
    logic [7:0]     ir_q, ir_d;
    logic           err_q, err_d;
    logic [W:0]     rot;

    logic rar, ral, rot_one, bsw, do_rot1, do_rot2;

    assign rar     = ir_q[IR_RAR];
    assign ral     = ir_q[IR_RAL];
    assign rot_one = rar ^ ral;

`ifdef OPR1_BSW_EN
    assign bsw = ir_q[IR_BSW] & ~rar & ~ral;
`else
    assign bsw = 1'b0;
`endif

    assign do_rot1 = rot_one | bsw;
    assign do_rot2 = rot_one & ir_q[IR_BSW];

    opr1_rotator u_rot (
        .din  ({l_q, ac_q}),
        .dir  (ral),
        .swap (bsw),
        .dout (rot)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= IDLE;
            ac_q  <= '0;
            l_q   <= 1'b0;
            ir_q  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= nxt;
            ac_q  <= ac_d;
            l_q   <= l_d;
            ir_q  <= ir_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        nxt   = state;
        ac_d  = ac_q;
        l_d   = l_q;
        ir_d  = ir_q;
        err_d = err_q;
        BUSY  = 1'b0;
        DONE  = 1'b0;
        ERR   = 1'b0;
        unique case (state)
            IDLE: begin
                if (START) begin
                    ac_d  = AC_IN;
                    l_d   = LINK_IN;
                    ir_d  = IR[7:0];
                    err_d = ~is_grp1(IR);
                    nxt   = is_grp1(IR) ? CLRCOM : FIN;
                end
            end
            CLRCOM: begin
                BUSY = 1'b1;
                ac_d = (ir_q[IR_CLA] ? '0 : ac_q) ^ {W{ir_q[IR_CMA]}};
                l_d  = (ir_q[IR_CLL] ? 1'b0 : l_q) ^ ir_q[IR_CML];
                if (ir_q[IR_IAC])
                    nxt = INC;
                else
                    nxt = do_rot1 ? ROT1 : FIN;
            end
            INC: begin
                BUSY        = 1'b1;
                {l_d, ac_d} = {l_q, ac_q} + {{W{1'b0}}, 1'b1};
                nxt         = do_rot1 ? ROT1 : FIN;
            end
            ROT1: begin
                BUSY        = 1'b1;
                {l_d, ac_d} = rot;
                nxt         = do_rot2 ? ROT2 : FIN;
            end
            ROT2: begin
                BUSY        = 1'b1;
                {l_d, ac_d} = rot;
                nxt         = FIN;
            end
            FIN: begin
                DONE = 1'b1;
                ERR  = err_q;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign AC_OUT   = ac_q;
    assign LINK_OUT = l_q;

endmodule

// File: tb/tb_opr1_sequencer.sv
// Randomized and directed checks of opr1_sequencer against an
// instruction-level model of group-1 operate semantics.
module tb_opr1_sequencer;

`ifdef OPR1_BSW_EN
    localparam bit BSW_ON = 1'b1;
`else
    localparam bit BSW_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        START = 1'b0;
    logic [11:0] IR = '0;
    logic [11:0] AC_IN = '0;
    logic        LINK_IN = 1'b0;
    logic [11:0] AC_OUT;
    logic        LINK_OUT;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int nvec = 0;
    int nbad = 0;

    opr1_sequencer dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .START    (START),
        .IR       (IR),
        .AC_IN    (AC_IN),
        .LINK_IN  (LINK_IN),
        .AC_OUT   (AC_OUT),
        .LINK_OUT (LINK_OUT),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction-level model: value arithmetic on a 13-bit integer.
    task automatic model(input logic [11:0] ir, input logic [11:0] ac,
                         input logic l, output logic [11:0] ac_o,
                         output logic l_o, output int steps,
                         output bit err);
        int v, a, li, n;
        steps = 0;
        err   = 1'b0;
        if (ir[11:8] != 4'b1110) begin
            err = 1'b1;
            ac_o = ac;
            l_o = l;
            return;
        end
        a  = ir[7] ? 0 : int'(ac);
        if (ir[5]) a = 4095 - a;
        li = ir[6] ? 0 : int'(l);
        if (ir[4]) li = 1 - li;
        v = li * 4096 + a;
        steps = 1;
        if (ir[0]) begin
            v = (v + 1) % 8192;
            steps++;
        end
        if (ir[3] != ir[2]) begin
            n = ir[1] ? 2 : 1;
            for (int i = 0; i < n; i++) begin
                if (ir[2]) v = (v * 2) % 8192 + v / 4096;
                else       v = v / 2 + (v % 2) * 4096;
            end
            steps += n;
        end else if (BSW_ON && ir[1] && !ir[3] && !ir[2]) begin
            a = v % 4096;
            v = (v / 4096) * 4096 + (a % 64) * 64 + a / 64;
            steps++;
        end
        ac_o = 12'(v % 4096);
        l_o  = v[12];
    endtask

    task automatic run(input logic [11:0] ir, input logic [11:0] ac,
                       input logic l);
        logic [11:0] eac;
        logic        el;
        int          steps, busy_n;
        bit          eerr, got;
        model(ir, ac, l, eac, el, steps, eerr);
        @(negedge CLK);
        IR = ir; AC_IN = ac; LINK_IN = l; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        IR = 12'($urandom); AC_IN = 12'($urandom); LINK_IN = 1'($urandom);
        busy_n = 0;
        got = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            if (DONE) begin
                got = 1'b1;
                chk("latency", k, steps + 1);
                chk("ac", AC_OUT, eac);
                chk("link", LINK_OUT, el);
                chk("err", ERR, eerr);
                chk("busy_cycles", busy_n, steps);
            end else begin
                if (BUSY) busy_n++;
                if (ERR) chk("err_without_done", ERR, 0);
                START = BUSY ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge CLK);
                START = 1'b0;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        @(negedge CLK);
        chk("done_pulse", DONE, 0);
        chk("hold_ac", AC_OUT, eac);
        chk("hold_link", LINK_OUT, el);
    endtask

    initial begin
        int seen;
        logic [11:0] rir;

        START = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_ac", AC_OUT, 0);
        chk("rst_link", LINK_OUT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        RESETN = 1'b1;
        START = 1'b0;
        @(negedge CLK);
        chk("rst_start_ignored", BUSY, 0);

        run(12'o7340, 12'o1234, 1'b1);
        chk("cla_cll_cma_ac", AC_OUT, 12'o7777);
        chk("cla_cll_cma_l", LINK_OUT, 0);
        run(12'o7001, 12'o7777, 1'b0);
        chk("iac_wrap_ac", AC_OUT, 12'o0000);
        chk("iac_wrap_l", LINK_OUT, 1);
        run(12'o7006, 12'o4000, 1'b0);
        chk("rtl_ac", AC_OUT, 12'o0001);
        chk("rtl_l", LINK_OUT, 0);
        run(12'o7012, 12'o0001, 1'b0);
        run(12'o7002, 12'o0077, 1'b0);
        chk("bsw_ac", AC_OUT, BSW_ON ? 12'o7700 : 12'o0077);
        run(12'o7016, 12'o1234, 1'b1);
        run(12'o1234, 12'o5555, 1'b1);
        chk("nonop_ac", AC_OUT, 12'o5555);
        chk("nonop_l", LINK_OUT, 1);

        for (int i = 0; i < 60; i++) begin
            rir = 12'($urandom);
            if ($urandom_range(0, 3) != 0) rir[11:8] = 4'b1110;
            run(rir, 12'($urandom), 1'($urandom));
        end

        @(negedge CLK);
        IR = 12'o7006; AC_IN = 12'o4000; LINK_IN = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        RESETN = 1'b0;
        START = 1'b1;
        @(negedge CLK);
        chk("abort_ac", AC_OUT, 0);
        chk("abort_link", LINK_OUT, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        RESETN = 1'b1;
        START = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge CLK);
            if (DONE || BUSY) seen++;
        end
        chk("abort_no_done", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
